// File: rtl/spi_flash_slave_if.sv
// SPI pins and backing-store fetch bus of the SPI flash read slave.
// The slave modport is the flash side; the master modport is the SPI host plus memory.
interface spi_flash_slave_if #(
    parameter int ADR_W = 24
);
    logic             spi_cs;
    logic             spi_sck;
    logic             spi_mosi;
    logic             spi_miso;
    logic             mem_cyc;
    logic [ADR_W-1:0] mem_adr;
    logic             mem_ack;
    logic [31:0]      mem_rdt;

    modport slave (
        input  spi_cs, spi_sck, spi_mosi, mem_ack, mem_rdt,
        output spi_miso, mem_cyc, mem_adr
    );

    modport master (
        output spi_cs, spi_sck, spi_mosi, mem_ack, mem_rdt,
        input  spi_miso, mem_cyc, mem_adr
    );
endinterface

// File: rtl/spi_flash_slave.sv
// SPI mode-0 flash read slave (0x03 read, 0x66/0x99 reset) oversampled on wb_clk; data lags sck by SYNC_STAGES+2 cycles.
// No backpressure: a byte whose word is not buffered when due goes out as 0xFF and sets the sticky underrun flag.
module spi_flash_slave #(
    parameter int SYNC_STAGES = 2,
    parameter int ADR_W       = 24
) (
    input  logic                 wb_clk,
    input  logic                 wb_rst_n,
    spi_flash_slave_if.slave     bus,
    output logic                 flash_rst,
    output logic                 underrun
);
    localparam int CNT_W = $clog2(ADR_W) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_BYTE  = CNT_W'(7);
    localparam logic [CNT_W-1:0] CNT_ADDR  = CNT_W'(ADR_W - 1);
    localparam logic [ADR_W-1:0] ADR_ONE   = ADR_W'(1);
    localparam logic [ADR_W-3:0] WORD_ONE  = (ADR_W-2)'(1);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;

    logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, mosi_sync_q, fill_q;
    logic                   sck_prev_q;
    logic                   cs_s, sck_s, mosi_s, fill_done, sck_rise, sck_fall;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [ADR_W-1:0] addr_q, addr_d;
    logic             armed_q, armed_d;
    logic             op_done_q, op_done_d;
    logic             op_66_q, op_66_d;
    logic             rst_en_q, rst_en_d;
    logic             flash_rst_q, flash_rst_d;
    logic             underrun_q, underrun_d;
    logic             mem_cyc_q, mem_cyc_d;
    logic [ADR_W-1:0] mem_adr_q, mem_adr_d;
    logic [31:0]      buf0_q, buf0_d, buf1_q, buf1_d;
    logic [1:0]       bvld_q, bvld_d;
    logic             cur_q, cur_d;
    logic             fill_sel_q, fill_sel_d;
    logic [7:0]       sh_q, sh_d;
    logic             need_load_q, need_load_d;
    logic             miso_q, miso_d;

    logic [7:0]       opcode;
    logic [ADR_W-1:0] addr_shift;
    logic [31:0]      cur_word;
    logic [7:0]       ld_byte;

    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sck_s     = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign fill_done = fill_q[SYNC_STAGES-1];
    assign sck_rise  = sck_s & ~sck_prev_q & ~cs_s;
    assign sck_fall  = ~sck_s & sck_prev_q & ~cs_s;

    assign opcode     = {cmd_q[6:0], mosi_s};
    assign addr_shift = {addr_q[ADR_W-2:0], mosi_s};
    assign cur_word   = cur_q ? buf1_q : buf0_q;
    assign ld_byte    = bvld_q[cur_q] ? cur_word[{addr_q[1:0], 3'b000} +: 8] : 8'hFF;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        armed_d     = armed_q | (fill_done & cs_s);
        op_done_d   = op_done_q;
        op_66_d     = op_66_q;
        rst_en_d    = rst_en_q;
        flash_rst_d = 1'b0;
        underrun_d  = underrun_q;
        mem_cyc_d   = mem_cyc_q;
        mem_adr_d   = mem_adr_q;
        buf0_d      = buf0_q;
        buf1_d      = buf1_q;
        bvld_d      = bvld_q;
        cur_d       = cur_q;
        fill_sel_d  = fill_sel_q;
        sh_d        = sh_q;
        need_load_d = need_load_q;
        miso_d      = miso_q;

        if (mem_cyc_q && bus.mem_ack) begin
            mem_cyc_d = 1'b0;
            if (fill_sel_q) buf1_d = bus.mem_rdt;
            else            buf0_d = bus.mem_rdt;
            bvld_d[fill_sel_q] = 1'b1;
        end

        case (state_q)
            IDLE: begin
                // armed_q blocks a frame already in progress when reset was released
                if (armed_q && !cs_s) begin
                    state_d   = CMD;
                    cnt_d     = '0;
                    op_done_d = 1'b0;
                    op_66_d   = 1'b0;
                end
            end
            CMD: begin
                if (sck_rise) begin
                    cmd_d = opcode;
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_BYTE) begin
                        op_done_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = IGNORE;
                        case (opcode)
                            8'h03: state_d = ADDR;
                            8'h66: begin
                                rst_en_d = 1'b1;
                                op_66_d  = 1'b1;
                            end
                            8'h99: begin
                                if (rst_en_q) begin
                                    flash_rst_d = 1'b1;
                                    rst_en_d    = 1'b0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ADDR: begin
                if (sck_rise) begin
                    addr_d = addr_shift;
                    cnt_d  = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_ADDR) begin
                        mem_cyc_d   = 1'b1;
                        mem_adr_d   = {addr_shift[ADR_W-1:2], 2'b00};
                        fill_sel_d  = 1'b0;
                        cur_d       = 1'b0;
                        bvld_d      = 2'b00;
                        cnt_d       = '0;
                        need_load_d = 1'b1;
                        state_d     = DATA;
                    end
                end
            end
            DATA: begin
                if (sck_fall) begin
                    if (need_load_q) begin
                        need_load_d = 1'b0;
                        sh_d        = ld_byte;
                        miso_d      = ld_byte[7];
                        if (!bvld_q[cur_q]) underrun_d = 1'b1;
                        // last byte of the word is starting: fetch the next word into the other buffer
                        if (addr_q[1:0] == 2'b11 && !mem_cyc_q) begin
                            mem_cyc_d      = 1'b1;
                            mem_adr_d      = {addr_q[ADR_W-1:2] + WORD_ONE, 2'b00};
                            fill_sel_d     = ~cur_q;
                            bvld_d[~cur_q] = 1'b0;
                        end
                    end else begin
                        sh_d   = {sh_q[6:0], 1'b1};
                        miso_d = sh_q[6];
                    end
                end
                if (sck_rise) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_BYTE) begin
                        cnt_d       = '0;
                        need_load_d = 1'b1;
                        addr_d      = addr_q + ADR_ONE;
                        if (addr_q[1:0] == 2'b11) begin
                            cur_d         = ~cur_q;
                            bvld_d[cur_q] = 1'b0;
                        end
                    end
                end
            end
            IGNORE: ;
            default: state_d = IDLE;
        endcase

        // A partial command byte leaves op_done clear, so rst_en survives it
        if (state_q != IDLE && cs_s) begin
            state_d = IDLE;
            if (op_done_q && !op_66_q) rst_en_d = 1'b0;
        end

        if (state_d != DATA) miso_d = 1'b1;
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            cs_sync_q   <= '1;
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            fill_q      <= '0;
            sck_prev_q  <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmd_q       <= '0;
            addr_q      <= '0;
            armed_q     <= 1'b0;
            op_done_q   <= 1'b0;
            op_66_q     <= 1'b0;
            rst_en_q    <= 1'b0;
            flash_rst_q <= 1'b0;
            underrun_q  <= 1'b0;
            mem_cyc_q   <= 1'b0;
            mem_adr_q   <= '0;
            buf0_q      <= '0;
            buf1_q      <= '0;
            bvld_q      <= 2'b00;
            cur_q       <= 1'b0;
            fill_sel_q  <= 1'b0;
            sh_q        <= 8'hFF;
            need_load_q <= 1'b0;
            miso_q      <= 1'b1;
        end else begin
            cs_sync_q[0]   <= bus.spi_cs;
            sck_sync_q[0]  <= bus.spi_sck;
            mosi_sync_q[0] <= bus.spi_mosi;
            fill_q[0]      <= 1'b1;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                cs_sync_q[i]   <= cs_sync_q[i-1];
                sck_sync_q[i]  <= sck_sync_q[i-1];
                mosi_sync_q[i] <= mosi_sync_q[i-1];
                fill_q[i]      <= fill_q[i-1];
            end
            sck_prev_q  <= sck_s;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            armed_q     <= armed_d;
            op_done_q   <= op_done_d;
            op_66_q     <= op_66_d;
            rst_en_q    <= rst_en_d;
            flash_rst_q <= flash_rst_d;
            underrun_q  <= underrun_d;
            mem_cyc_q   <= mem_cyc_d;
            mem_adr_q   <= mem_adr_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            bvld_q      <= bvld_d;
            cur_q       <= cur_d;
            fill_sel_q  <= fill_sel_d;
            sh_q        <= sh_d;
            need_load_q <= need_load_d;
            miso_q      <= miso_d;
        end
    end

    assign bus.spi_miso = miso_q;
    assign bus.mem_cyc  = mem_cyc_q;
    assign bus.mem_adr  = mem_adr_q;
    assign flash_rst    = flash_rst_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_spi_flash_slave.sv
// Directed bench for spi_flash_slave: table of read vectors plus hand-written reset/underrun/abort sequences.
module tb_spi_flash_slave;
    localparam int HALF = 10;

    logic wb_clk = 1'b0;
    logic wb_rst_n;
    logic flash_rst;
    logic underrun;

    spi_flash_slave_if #(.ADR_W(24)) ifc();

    spi_flash_slave #(.SYNC_STAGES(2), .ADR_W(24)) dut (
        .wb_clk   (wb_clk),
        .wb_rst_n (wb_rst_n),
        .bus      (ifc.slave),
        .flash_rst(flash_rst),
        .underrun (underrun)
    );

    always #5 wb_clk = ~wb_clk;

    int checks = 0;
    int errors = 0;
    int ack_delay = 2;
    int rst_pulses = 0;
    logic [23:0] fetch_log[$];

    typedef struct {
        logic [23:0] adr;
        int          nb;
        logic [23:0] f0;
        logic [23:0] f1;
        logic [63:0] d;
    } vec_t;
    vec_t vecs[4];

    function automatic logic [31:0] mem_word(input logic [23:0] a);
        case (a)
            24'h100008: return 32'h44332211;
            24'h10000C: return 32'h88776655;
            24'h100010: return 32'hCAFEF00D;
            24'h000000: return 32'hDDCCBBAA;
            24'h000004: return 32'h0C0B0A09;
            24'h000008: return 32'h14131211;
            24'hFFFFFC: return 32'h04030201;
            default:    return 32'h00000000;
        endcase
    endfunction

    always @(posedge wb_clk) if (flash_rst === 1'b1) rst_pulses++;

    initial begin
        ifc.mem_ack = 1'b0;
        ifc.mem_rdt = '0;
        forever begin
            @(negedge wb_clk);
            if (ifc.mem_cyc === 1'b1) begin
                fetch_log.push_back(ifc.mem_adr);
                repeat (ack_delay - 1) @(negedge wb_clk);
                ifc.mem_rdt = mem_word(ifc.mem_adr);
                ifc.mem_ack = 1'b1;
                @(negedge wb_clk);
                ifc.mem_ack = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic spi_bit(input logic b, output logic r);
        ifc.spi_mosi = b;
        repeat (HALF) @(negedge wb_clk);
        r = ifc.spi_miso;
        ifc.spi_sck = 1'b1;
        repeat (HALF) @(negedge wb_clk);
        ifc.spi_sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
        logic rb;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(b[i], rb);
            r[i] = rb;
        end
    endtask

    task automatic cs_low();
        ifc.spi_cs = 1'b0;
        repeat (HALF) @(negedge wb_clk);
    endtask

    task automatic cs_high();
        repeat (HALF) @(negedge wb_clk);
        ifc.spi_cs = 1'b1;
        repeat (4 * HALF) @(negedge wb_clk);
    endtask

    task automatic cmd_frame(input logic [7:0] op);
        logic [7:0] r;
        cs_low();
        spi_byte(op, r);
        cs_high();
    endtask

    task automatic do_read(input logic [23:0] adr, input int nb,
                           output logic [63:0] got, output logic [7:0] cmd_rb);
        logic [7:0] r;
        got = '0;
        cs_low();
        spi_byte(8'h03, cmd_rb);
        spi_byte(adr[23:16], r);
        spi_byte(adr[15:8], r);
        spi_byte(adr[7:0], r);
        for (int b = 0; b < nb; b++) begin
            spi_byte(8'h00, r);
            got[63-8*b -: 8] = r;
        end
        cs_high();
    endtask

    initial begin
        logic [63:0] got;
        logic [7:0]  rb;
        logic        bit_r;
        int          base;
        int          p0;

        vecs[0] = '{adr: 24'h100008, nb: 8, f0: 24'h100008, f1: 24'h10000C, d: 64'h1122334455667788};
        vecs[1] = '{adr: 24'h000002, nb: 3, f0: 24'h000000, f1: 24'h000004, d: 64'hCCDD090000000000};
        vecs[2] = '{adr: 24'hFFFFFC, nb: 8, f0: 24'hFFFFFC, f1: 24'h000000, d: 64'h01020304AABBCCDD};
        vecs[3] = '{adr: 24'h000007, nb: 2, f0: 24'h000004, f1: 24'h000008, d: 64'h0C11000000000000};

        ifc.spi_cs   = 1'b1;
        ifc.spi_sck  = 1'b0;
        ifc.spi_mosi = 1'b0;
        wb_rst_n     = 1'b0;
        repeat (5) @(negedge wb_clk);
        check("reset miso", ifc.spi_miso, 1'b1);
        check("reset mem_cyc", ifc.mem_cyc, 1'b0);
        check("reset mem_adr", ifc.mem_adr, 24'h0);
        check("reset flash_rst", flash_rst, 1'b0);
        check("reset underrun", underrun, 1'b0);
        wb_rst_n = 1'b1;
        repeat (4 * HALF) @(negedge wb_clk);

        for (int i = 0; i < 4; i++) begin
            base = fetch_log.size();
            do_read(vecs[i].adr, vecs[i].nb, got, rb);
            check($sformatf("v%0d miso during cmd", i), rb, 8'hFF);
            check($sformatf("v%0d fetch count", i), 64'(fetch_log.size() - base >= 2), 1);
            if (fetch_log.size() >= base + 2) begin
                check($sformatf("v%0d first mem_adr", i), fetch_log[base], vecs[i].f0);
                check($sformatf("v%0d second mem_adr", i), fetch_log[base+1], vecs[i].f1);
            end
            for (int b = 0; b < vecs[i].nb; b++)
                check($sformatf("v%0d byte%0d", i, b), got[63-8*b -: 8], vecs[i].d[63-8*b -: 8]);
        end
        check("underrun clear after normal reads", underrun, 1'b0);

        p0 = rst_pulses;
        cmd_frame(8'h66);
        check("no pulse on 0x66", rst_pulses - p0, 0);
        cmd_frame(8'h99);
        check("pulse 0x66,0x99", rst_pulses - p0, 1);
        cmd_frame(8'h99);
        check("0x99 consumes rst_en", rst_pulses - p0, 1);

        p0 = rst_pulses;
        cmd_frame(8'h99);
        check("0x99 alone", rst_pulses - p0, 0);

        p0 = rst_pulses;
        cmd_frame(8'h66);
        do_read(24'h100008, 1, got, rb);
        cmd_frame(8'h99);
        check("0x66,0x03,0x99", rst_pulses - p0, 0);

        p0 = rst_pulses;
        cmd_frame(8'h66);
        cs_low();
        for (int i = 0; i < 4; i++) spi_bit(1'b1, bit_r);
        cs_high();
        cmd_frame(8'h99);
        check("partial cmd keeps rst_en", rst_pulses - p0, 1);

        base = fetch_log.size();
        cs_low();
        spi_byte(8'h03, rb);
        for (int i = 0; i < 12; i++) spi_bit(1'b0, bit_r);
        cs_high();
        check("12 addr bits no fetch", fetch_log.size() - base, 0);
        check("12 addr bits mem_cyc", ifc.mem_cyc, 1'b0);
        do_read(24'h100008, 2, got, rb);
        check("read after abort b0", got[63:56], 8'h11);
        check("read after abort b1", got[55:48], 8'h22);

        base = fetch_log.size();
        cs_low();
        spi_byte(8'h03, rb);
        spi_byte(8'h10, rb);
        wb_rst_n = 1'b0;
        repeat (3) @(negedge wb_clk);
        wb_rst_n = 1'b1;
        spi_byte(8'h00, rb);
        spi_byte(8'h08, rb);
        spi_byte(8'h00, rb);
        cs_high();
        check("reset mid-frame no fetch", fetch_log.size() - base, 0);
        check("reset mid-frame miso", rb, 8'hFF);
        do_read(24'h100008, 1, got, rb);
        check("read after reset", got[63:56], 8'h11);

        ack_delay = 200;
        do_read(24'h100008, 2, got, rb);
        ack_delay = 2;
        check("late ack byte", got[63:56], 8'hFF);
        check("underrun set", underrun, 1'b1);
        do_read(24'h100008, 1, got, rb);
        check("read after underrun", got[63:56], 8'h11);
        check("underrun sticky", underrun, 1'b1);
        wb_rst_n = 1'b0;
        repeat (3) @(negedge wb_clk);
        check("underrun cleared by reset", underrun, 1'b0);
        wb_rst_n = 1'b1;
        repeat (4 * HALF) @(negedge wb_clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_flash_slave.md
SPI_FLASH_SLAVE -- requirements
Module: spi_flash_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the number of synchroniser flops on spi_cs, spi_sck and spi_mosi.
REQ-002 SHALL have parameter ADR_W, default 24, the flash byte-address width.
REQ-003 wb_clk  in  1  the single clock; all logic is on its rising edge.
REQ-004 wb_rst_n  in  1  asynchronous, active-low reset.
REQ-005 spi_cs  in  1  chip select from the SPI master, active low.
REQ-006 spi_sck  in  1  SPI clock, mode 0, asynchronous to wb_clk.
REQ-007 spi_mosi  in  1  command/address bits, MSB first.
REQ-008 spi_miso  out  1  read data bits, MSB first.
REQ-009 mem_cyc  out  1  word-fetch request to the backing store.
REQ-010 mem_adr  out  ADR_W  byte address of the fetch; bits [1:0] are always 0.
REQ-011 mem_ack  in  1  one-cycle fetch completion.
REQ-012 mem_rdt  in  32  fetched word, little-endian: byte at A+0 is in [7:0].
REQ-013 flash_rst  out  1  one-cycle pulse when a valid software reset is accepted.
REQ-014 underrun  out  1  sticky flag: a data byte was needed before its fetch completed.

Function
REQ-015 SHALL synchronise cs/sck/mosi through SYNC_STAGES flops and detect sck rise/fall from the last two synchronised sck samples.
REQ-016 SHALL sample synchronised mosi on each detected sck rise while cs is low.
REQ-017 SHALL update spi_miso only on detected sck falls while cs is low.
REQ-018 Timing contract: sck half-period >= 8 wb_clk cycles; mem_ack <= 4 cycles after mem_cyc rises.
REQ-019 FSM states SHALL be IDLE, CMD, ADDR, DATA, IGNORE.
REQ-020 IDLE -> CMD on synchronised cs falling.
REQ-021 Any state -> IDLE on synchronised cs high, within 1 cycle of sync output; drop mem_cyc only after a pending mem_ack.
REQ-022 CMD SHALL collect 8 bits; its next state depends on the opcode.
REQ-023 Opcode 0x03 -> ADDR.
REQ-024 Opcode 0x66 -> IGNORE and set rst_en.
REQ-025 Opcode 0x99 -> IGNORE; pulse flash_rst at the 8th rise if rst_en was set.
REQ-026 Any other opcode -> IGNORE.
REQ-027 rst_en SHALL clear at the end of any CS frame whose opcode is not 0x66, and an accepted 0x99 SHALL consume it; 0x99 not immediately preceded by a 0x66 frame produces no pulse.
REQ-028 ADDR SHALL collect ADR_W bits MSB first; on the last rise, raise mem_cyc with mem_adr = addr & ~3 and enter DATA.
REQ-029 mem_cyc SHALL stay high until mem_ack; mem_rdt is latched into a 32-bit data buffer on mem_ack.
REQ-030 DATA SHALL shift byte mem_rdt[8*(A%4)+7 : 8*(A%4)] MSB first; first bit is driven on the fall after the last address rise.
REQ-031 The byte address SHALL increment after each 8 bits.
REQ-032 When the last byte of a word starts shifting, SHALL prefetch the next word (mem_adr + 4) into a second buffer.
REQ-033 Address and prefetch SHALL wrap from 2^ADR_W-1 to 0.
REQ-034 Unaligned start (A%4 != 0) SHALL send the remaining bytes of the first word, then continue aligned.
REQ-035 If a byte's word is not buffered when its first bit is due, SHALL send 0xFF for that byte and set underrun.
REQ-036 IGNORE SHALL accept and discard bits until cs goes high.
REQ-037 spi_miso SHALL be 1 outside DATA.
REQ-038 A partial command byte at cs rise SHALL be discarded with no effect on rst_en.

Reset
REQ-039 While wb_rst_n = 0, SHALL hold: state IDLE, spi_miso 1, mem_cyc 0, mem_adr 0, flash_rst 0, underrun 0, rst_en 0, both buffers invalid, synchronisers at cs=1/sck=0/mosi=0.
REQ-040 Reset asserted mid-frame SHALL abort the frame.
REQ-041 After release, SHALL ignore the current frame until cs has been high.

Verification
REQ-042 Read 0x03 addr 0x100008, memory word 0x44332211, 8 bytes -> mem_adr 0x100008 then 0x10000C; MISO 0x11,0x22,0x33,0x44 then the next word's bytes.
REQ-043 Read at 0x000002 of word 0xDDCCBBAA -> MISO 0xCC,0xDD, then the byte at 0x000004.
REQ-044 Read at 0xFFFFFC, 8 bytes -> second fetch mem_adr 0x000000 (wrap).
REQ-045 Frame 0x66, then frame 0x99 -> one flash_rst pulse. Frame 0x99 alone, or 0x66,0x03..,0x99 -> no pulse.
REQ-046 mem_ack withheld 200 cycles on the first fetch -> first byte 0xFF, underrun=1, sticky until wb_rst_n low.
REQ-047 cs raised after 12 address bits -> no mem_cyc, back to IDLE; a following read works normally.
